// File: rtl/divider_arbiter_if.sv
// Requester and shared-divider bundle for divider_arbiter.
// master: requesters plus divider side; slave: the arbiter.
interface divider_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int REQ_N = 4,
  parameter int ID_W  = $clog2(REQ_N)
);
  logic [REQ_N-1:0]       req;
  logic [REQ_N*WIDTH-1:0] req_dividend;
  logic [REQ_N*WIDTH-1:0] req_divisor;
  logic [REQ_N-1:0]       gnt;
  logic [REQ_N-1:0]       done;
  logic [WIDTH-1:0]       res_quotient;
  logic [WIDTH-1:0]       res_remainder;
  logic                   res_zero_err;
  logic [ID_W-1:0]        res_id;
  logic                   div_start;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic [WIDTH-1:0]       div_quotient;
  logic [WIDTH-1:0]       div_remainder;
  logic                   div_zero_err;
  logic                   div_valid;

  modport master (
    output req, req_dividend, req_divisor,
    output div_quotient, div_remainder,
    output div_zero_err, div_valid,
    input  gnt, done, res_quotient,
    input  res_remainder, res_zero_err, res_id,
    input  div_start, div_dividend, div_divisor
  );

  modport slave (
    input  req, req_dividend, req_divisor,
    input  div_quotient, div_remainder,
    input  div_zero_err, div_valid,
    output gnt, done, res_quotient,
    output res_remainder, res_zero_err, res_id,
    output div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/divider_arbiter.sv
// Shares one sequential divider between REQ_N requesters.
// Define DIV_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module divider_arbiter #(
  parameter int WIDTH = 32,
  parameter int REQ_N = 4,
  parameter int ID_W  = $clog2(REQ_N)
) (
  input logic clk,
  input logic rst,
  divider_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_start;
  logic             w_any;
  logic [ID_W-1:0]  w_win;
  logic [REQ_N-1:0] w_win_oh;
  logic [REQ_N-1:0] w_id_oh;
  logic [REQ_N-1:0] r_gnt;
  logic [REQ_N-1:0] r_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_zerr;
  logic [ID_W-1:0]  r_id;

  assign w_any    = |io_bus.req;
  assign w_win_oh = REQ_N'(1) << w_win;
  assign w_id_oh  = REQ_N'(1) << r_id;

`ifdef DIV_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;
  int              w_idx;

  // Winner: first requester after the last winner, wrapping.
  always_comb begin
    w_win = '0;
    w_idx = 0;
    for (int k = REQ_N; k >= 1; k--) begin
      w_idx = (int'(r_ptr) + k) % REQ_N;
      if (io_bus.req[w_idx]) w_win = ID_W'(w_idx);
    end
  end

  // Remember the last winner; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= ID_W'(REQ_N - 1);
    else if (r_state == S_IDLE && w_any)
      r_ptr <= w_win;
  end
`else
  // Winner: lowest-index requester.
  always_comb begin
    w_win = '0;
    for (int i = REQ_N - 1; i >= 0; i--)
      if (io_bus.req[i]) w_win = ID_W'(i);
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and the one-cycle divider start.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT:  if (io_bus.div_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch operands on grant, results on divider valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt  <= '0;
      r_done <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_zerr <= 1'b0;
      r_id   <= '0;
    end else begin
      r_done <= '0;
      if (r_state == S_IDLE && w_any) begin
        r_gnt <= w_win_oh;
        r_a   <= io_bus.req_dividend[w_win*WIDTH +: WIDTH];
        r_b   <= io_bus.req_divisor[w_win*WIDTH +: WIDTH];
        r_id  <= w_win;
      end
      if (r_state == S_WAIT && io_bus.div_valid) begin
        r_q    <= io_bus.div_quotient;
        r_r    <= io_bus.div_remainder;
        r_zerr <= io_bus.div_zero_err;
        r_done <= w_id_oh;
        r_gnt  <= '0;
      end
    end
  end

  assign io_bus.gnt           = r_gnt;
  assign io_bus.done          = r_done;
  assign io_bus.res_quotient  = r_q;
  assign io_bus.res_remainder = r_r;
  assign io_bus.res_zero_err  = r_zerr;
  assign io_bus.res_id        = r_id;
  assign io_bus.div_start     = w_start;
  assign io_bus.div_dividend  = r_a;
  assign io_bus.div_divisor   = r_b;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: behavioural divider plus a
// job-level reference model of arbitration and results.
module tb_divider_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_arbiter_if #(.WIDTH(W), .REQ_N(N), .ID_W(IW)) bus ();

  divider_arbiter #(.WIDTH(W), .REQ_N(N), .ID_W(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh2i(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference arbitration from the requester set and last winner.
  function automatic int arb(logic [N-1:0] r, int last);
    int w;
    w = -1;
`ifdef DIV_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (w < 0 && r[(last + k) % N]) w = (last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (w < 0 && r[i]) w = i;
`endif
    return w;
  endfunction

  // Inputs as seen on each rising edge.
  logic [N-1:0]   p_req;
  logic [N*W-1:0] p_a, p_b;
  logic           p_valid, p_rst;
  bit             p_ok = 0;

  initial forever begin
    @(posedge clk);
    p_req   = bus.req;
    p_a     = bus.req_dividend;
    p_b     = bus.req_divisor;
    p_valid = bus.div_valid;
    p_rst   = rst;
    p_ok    = 1;
  end

  // Behavioural shared divider; zero divisor answers next cycle.
  int          lat = 4;
  bit          spur = 0;
  bit          dbusy = 0;
  int          dcnt = 0;
  logic [W-1:0] da, db;

  initial begin
    bus.div_valid     = 0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    bus.div_zero_err  = 0;
    forever begin
      @(negedge clk);
      bus.div_valid = 0;
      if (p_ok && p_rst) begin
        dbusy = 0;
      end else begin
        if (spur && !dbusy) begin
          bus.div_valid = 1;
          spur = 0;
        end
        if (dbusy) begin
          dcnt--;
          if (dcnt == 0) begin
            dbusy = 0;
            bus.div_valid = 1;
            if (db == 0) begin
              bus.div_quotient  = '1;
              bus.div_remainder = da;
              bus.div_zero_err  = 1;
            end else begin
              bus.div_quotient  = da / db;
              bus.div_remainder = da % db;
              bus.div_zero_err  = 0;
            end
          end
        end else if (bus.div_start) begin
          dbusy = 1;
          da    = bus.div_dividend;
          db    = bus.div_divisor;
          dcnt  = (db == 0) ? 1 : lat;
        end
      end
    end
  end

  // Job-level reference model, checked every cycle.
  bit           m_active = 0, m_issue = 0;
  int           m_id = 0, m_last = N - 1;
  logic [W-1:0] m_a, m_b, m_q = '0, m_r = '0;
  logic         m_z = 0;
  int           m_rid = 0;
  logic [N-1:0] m_done;

  initial forever begin
    @(negedge clk);
    if (p_ok) begin
      m_done = '0;
      if (p_rst) begin
        m_active = 0; m_issue = 0;
        m_last = N - 1; m_rid = 0;
        m_q = '0; m_r = '0; m_z = 0;
        m_a = '0; m_b = '0;
      end else if (m_active && m_issue) begin
        m_issue = 0;
      end else if (m_active && p_valid) begin
        m_active = 0;
        m_done   = N'(1) << m_id;
        if (m_b == 0) begin
          m_q = '1; m_r = m_a; m_z = 1;
        end else begin
          m_q = m_a / m_b; m_r = m_a % m_b; m_z = 0;
        end
      end else if (!m_active && p_req != 0) begin
        m_id     = arb(p_req, m_last);
        m_last   = m_id;
        m_rid    = m_id;
        m_active = 1;
        m_issue  = 1;
        m_a      = p_a[m_id*W +: W];
        m_b      = p_b[m_id*W +: W];
      end
      chk("gnt", bus.gnt, m_active ? N'(1) << m_id : '0);
      chk("div_start", bus.div_start, m_issue);
      chk("done", bus.done, m_done);
      chk("res_q", bus.res_quotient, m_q);
      chk("res_r", bus.res_remainder, m_r);
      chk("res_z", bus.res_zero_err, m_z);
      chk("res_id", bus.res_id, m_rid);
      if (m_active) begin
        chk("div_a", bus.div_dividend, m_a);
        chk("div_b", bus.div_divisor, m_b);
      end
    end
  end

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    bus.req_dividend[i*W +: W] = a;
    bus.req_divisor[i*W +: W]  = b;
  endtask

  task automatic wait_gnt(int i, output bit ok);
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.gnt[i]) ok = 1;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(int i, output int cyc);
    bit ok;
    ok = 0;
    cyc = 0;
    for (int c = 1; c <= 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.done[i]) begin
        ok = 1;
        cyc = c;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic job(int i, logic [W-1:0] a, logic [W-1:0] b);
    bit ok;
    int c;
    bus.req[i] = 1;
    set_op(i, a, b);
    wait_gnt(i, ok);
    bus.req[i] = 0;
    if (ok) wait_done(i, c);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  int gq[$];

  task automatic collect(int n);
    logic [N-1:0] pg, pd;
    pg = bus.gnt;
    pd = bus.done;
    for (int c = 0; c < 600 && gq.size() < n; c++) begin
      @(negedge clk);
      if (pd != 0) chk("b2b_gnt", bus.gnt != 0, 1);
      if (bus.gnt != 0 && pg == 0) gq.push_back(oh2i(bus.gnt));
      pg = bus.gnt;
      pd = bus.done;
    end
    if (gq.size() < n) chk("grant_count", gq.size(), n);
  endtask

  initial begin
    bit ok;
    int c, nd;
    rst = 1;
    bus.req = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_start", bus.div_start, 0);
    chk("rst_div_a", bus.div_dividend, 0);
    rst = 0;

    // Stray divider valid while idle.
    spur = 1;
    repeat (4) @(negedge clk);

    // Single job.
    lat = 6;
    job(2, 100, 7);
    chk("t1_q", bus.res_quotient, 14);
    chk("t1_r", bus.res_remainder, 2);
    chk("t1_id", bus.res_id, 2);
    chk("t1_z", bus.res_zero_err, 0);

    // Zero divisor.
    bus.req[1] = 1;
    set_op(1, 55, 0);
    wait_gnt(1, ok);
    bus.req[1] = 0;
    if (ok) begin
      wait_done(1, c);
      chk("zd_latency", c, 2);
      chk("zd_z", bus.res_zero_err, 1);
    end

    // Operands change after grant.
    bus.req[0] = 1;
    set_op(0, 32'hFFFF_FFFF, 16);
    wait_gnt(0, ok);
    bus.req[0] = 0;
    set_op(0, 1, 1);
    if (ok) begin
      wait_done(0, c);
      chk("oc_q", bus.res_quotient, 32'h0FFF_FFFF);
      chk("oc_r", bus.res_remainder, 15);
    end

    // Contention.
    do_reset();
    lat = 3;
    gq.delete();
    for (int i = 0; i < N; i++) set_op(i, 1000 + i, 3 + i);
`ifdef DIV_ARB_ROUND_ROBIN_EN
    bus.req = 4'b1111;
    collect(5);
    bus.req = '0;
    if (gq.size() == 5) begin
      chk("rr0", gq[0], 0);
      chk("rr1", gq[1], 1);
      chk("rr2", gq[2], 2);
      chk("rr3", gq[3], 3);
      chk("rr4", gq[4], 0);
    end
`else
    bus.req = 4'b1010;
    collect(4);
    bus.req = '0;
    foreach (gq[k]) chk("fp_win", gq[k], 1);
`endif
    repeat (10) @(negedge clk);

    // Reset during a long divide.
    lat = 32;
    bus.req[0] = 1;
    set_op(0, 32'hDEAD_BEEF, 7);
    wait_gnt(0, ok);
    bus.req[0] = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mr_gnt", bus.gnt, 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done != 0) nd++;
    end
    chk("mr_nodone", nd, 0);
    lat = 5;
    job(3, 1000, 3);
    chk("mr_q", bus.res_quotient, 333);
    chk("mr_r", bus.res_remainder, 1);
    chk("mr_id", bus.res_id, 3);

    // Randomised traffic.
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      lat = $urandom_range(1, 12);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) spur = 1;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i] && $urandom_range(0, 1) == 1) begin
          bus.req[i] = 0;
          set_op(i, $urandom, $urandom);
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1;
          set_op(i, $urandom,
                 ($urandom_range(0, 7) == 0) ? 0 :
                 32'($urandom_range(1, 300)));
        end
      end
    end
    rst = 0;
    bus.req = '0;
    repeat (60) @(negedge clk);
    chk("drain_gnt", bus.gnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one sequential `divider` instance between `REQ_N` requesters. It arbitrates pending requests and latches the winner's operands. It then sequences the divider's start/valid handshake and returns quotient, remainder and zero-divide flag to the winner with a one-cycle done pulse. It sits between the requester ports and the shared divider; the divider's outputs feed back into it.

## Interface
- `WIDTH`, 32, operand/result width; must match the divider's `WIDTH`.
- `REQ_N`, 4, number of requesters, ≥2.
- `ID_W`, `$clog2(REQ_N)`, derived, width of `res_id`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  REQ_N  per-requester request level.
- `req_dividend`  in  REQ_N*WIDTH  requester i operand at bits [i*WIDTH +: WIDTH].
- `req_divisor`  in  REQ_N*WIDTH  same packing.
- `gnt`  out  REQ_N  one-hot; high from grant until done.
- `done`  out  REQ_N  one-hot, one-cycle pulse: result ready for that requester.
- `res_quotient`  out  WIDTH  registered quotient of the last completed job.
- `res_remainder`  out  WIDTH  registered remainder.
- `res_zero_err`  out  1  registered divide-by-zero flag.
- `res_id`  out  ID_W  index of the requester owning the current `res_*`.
- `div_start`  out  1  to the divider's `start`.
- `div_dividend`, `div_divisor`  out  WIDTH  to the divider's operands; registered and stable from ISSUE through WAIT.
- `div_quotient`, `div_remainder`  in  WIDTH  from the divider.
- `div_zero_err`, `div_valid`  in  1  from the divider's `zeroErr` and `valid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any `req` bit is set, pick a winner.
  - On the edge: set `gnt[w]`, latch operand w into `div_dividend`/`div_divisor`, latch `res_id` ← w, go to ISSUE.
  - If no `req` bit is set, stay in IDLE.
- **ISSUE**
  - `div_start` = 1 for exactly this cycle.
  - Next state is WAIT, unconditionally.
- **WAIT**
  - `div_start` = 0.
  - When `div_valid` = 1: capture the `div_*` results into `res_*`, pulse `done[res_id]` next cycle, clear `gnt`, go to IDLE.
- Requester protocol:
  - Operands are sampled only on the grant edge; the requester may change them afterwards.
  - `req` must stay high until `gnt`. Dropping `req` after grant does not abort the job; the result is still delivered.
  - A requester holding `req` high across its `done` is re-arbitrated as a new job.
- Zero divisor: the divider does not enter calculation; `div_valid` rises the cycle after start. The result is delivered with `res_zero_err` = 1; `res_quotient`/`res_remainder` carry whatever the divider presents.
- `div_valid` is ignored outside WAIT, including after reset, before the first job.
- Simultaneous `done` and a new `req` in the same cycle: legal. Arbitration happens in that IDLE cycle.

## Timing
- Reset values: state IDLE; `gnt`, `done`, `div_start` = 0; `res_quotient`, `res_remainder`, `div_dividend`, `div_divisor` = 0; `res_zero_err` = 0; `res_id` = 0; round-robin pointer = REQ_N-1, so requester 0 has priority first.
- `rst` mid-operation: on the next edge, return to IDLE. The in-flight job is discarded and no `done` is issued. `rst` must also drive the divider's `rst`.
- Cycle sequence from `req` high in IDLE at cycle t:
  - t+1: `gnt` and `div_start`.
  - t+2: first WAIT cycle.
  - Divider valid at cycle v ≥ t+2.
  - v+1: `done` pulse with `res_*` valid. `res_*` hold until the next completion.
- Back-to-back throughput: one IDLE cycle between a `done` and the next `div_start`.
- `gnt` never has more than one bit set. `done` never coincides with a different `gnt` bit.

## Configuration
- Macro `DIV_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - Search starts at (last winner + 1) mod REQ_N and wraps.
  - The pointer updates on each grant.
- **Undefined:** fixed priority; lowest index wins. The pointer register is not generated.

## Test plan
- Single job: `req[2]`, 100/7 → `gnt` = 4'b0100, one `div_start` pulse, `done` = 4'b0100, quotient 14, remainder 2, `res_id` 2, `res_zero_err` 0.
- Zero divisor: `req[1]`, 55/0 → `done[1]` two cycles after `div_start`, `res_zero_err` = 1.
- Contention, macro defined: all four `req` held high → grants in order 0,1,2,3,0; each `done` precedes the next `gnt` by one IDLE cycle.
- Contention, macro undefined: `req[3]` and `req[1]` held high → requester 1 is granted repeatedly; 3 is never granted while 1 is held.
- Operand change after grant: requester 0 sends 0xFFFFFFFF/16, then changes operands to 1/1 the cycle after `gnt` → quotient 0x0FFFFFFF, remainder 15.
- Reset mid-WAIT: assert `rst` for one cycle during a 32-bit divide → `gnt` = 0, no `done`; the next request completes correctly.
